// File: rtl/lifo_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lifo_cmd_ctrl: push/pop command front-end for an external LIFO stack,    |
// | with a shadow level counter; LIFO_CMD_ERR_CNT_EN adds err_cnt. Rev 1.0   |
// +--------------------------------------------------------------------------+
module lifo_cmd_ctrl #(
  parameter int DEPTH = 16,
  parameter int DW    = 4
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [DW-1:0]            cmd_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err,
  output logic                     stk_en,
  output logic                     stk_rw,
  output logic [DW-1:0]            stk_din,
  input  logic [DW-1:0]            stk_dout,
  input  logic                     stk_full,
  input  logic                     stk_empty,
  output logic [$clog2(DEPTH):0]   level
`ifdef LIFO_CMD_ERR_CNT_EN
  ,
  output logic [7:0]               err_cnt
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] c_depth = LW'(DEPTH);
  localparam logic [LW-1:0] c_one   = LW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_op;
  logic [DW-1:0]   r_data;
  logic            w_reject;

  // Decided in the ISSUE cycle itself so the flags seen are the current ones.
  assign w_reject = r_op ? ((level == '0) || stk_empty)
                         : ((level == c_depth) || stk_full);

  assign stk_en  = (r_state == ISSUE) && !w_reject;
  assign stk_rw  = stk_en && r_op;
  assign stk_din = stk_en ? r_data : '0;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= IDLE;
      r_op      <= 1'b0;
      r_data    <= '0;
      level     <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_op      <= cmd_op;
            r_data    <= cmd_data;
            cmd_ready <= 1'b0;
            r_state   <= ISSUE;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ISSUE: begin
          if (w_reject) begin
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            r_state   <= RESP;
          end else begin
            level   <= r_op ? (level - c_one) : (level + c_one);
            r_state <= WAIT;
          end
        end
        WAIT: begin
          rsp_data  <= r_op ? stk_dout : '0;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            cmd_ready <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LIFO_CMD_ERR_CNT_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_cnt <= 8'd0;
    end else if ((r_state == ISSUE) && w_reject && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lifo_cmd_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lifo_cmd_ctrl: vector table, corner sequences and random commands     |
// | against a queue-based stack model. Rev 1.0                               |
// +--------------------------------------------------------------------------+
module tb_lifo_cmd_ctrl;

  localparam int DEPTH = 16;
  localparam int DW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [DW-1:0] cmd_data;
  logic          rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_data;
  logic          stk_en, stk_rw;
  logic [DW-1:0] stk_din, stk_dout;
  logic          stk_full, stk_empty;
  logic [4:0]    level;
`ifdef LIFO_CMD_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  lifo_cmd_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
    .Clk       (clk),
    .Rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .stk_en    (stk_en),
    .stk_rw    (stk_rw),
    .stk_din   (stk_din),
    .stk_dout  (stk_dout),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .level     (level)
`ifdef LIFO_CMD_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Downstream stack with registered read data.
  logic [DW-1:0] smem [0:DEPTH-1];
  logic [4:0]    scnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      scnt     <= 5'd0;
      stk_dout <= '0;
    end else if (stk_en) begin
      if (!stk_rw && scnt < 5'd16) begin
        smem[scnt[3:0]] <= stk_din;
        scnt            <= scnt + 5'd1;
      end else if (stk_rw && scnt > 5'd0) begin
        stk_dout <= smem[4'(scnt - 5'd1)];
        scnt     <= scnt - 5'd1;
      end
    end
  end
  assign stk_full  = (scnt == 5'd16);
  assign stk_empty = (scnt == 5'd0);

  int            n_checks = 0;
  int            n_fail   = 0;
  int            exp_errs = 0;
  logic [DW-1:0] ref_q [$];

  typedef struct {
    logic          op;
    logic [DW-1:0] data;
    int            hold;
    logic          err;
    logic [DW-1:0] rdata;
    int            lvl;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full command with cycle-exact latency checks; inputs change at negedge.
  task automatic do_cmd(input logic op, input logic [DW-1:0] data, input int hold,
                        input logic exp_err, input logic [DW-1:0] exp_data, input int exp_level);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; rsp_ready = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_data = DW'($urandom);
    check("stk_en_issue", stk_en, !exp_err);
    check("stk_rw_issue", stk_rw, exp_err ? 1'b0 : op);
    check("stk_din_issue", stk_din, exp_err ? '0 : data);
    check("cmd_ready_busy", cmd_ready, 0);
    @(negedge clk);
    check("stk_en_pulse_end", stk_en, 0);
    check("rsp_valid_n2", rsp_valid, exp_err);
    if (!exp_err) begin
      check("level_after_issue", level, exp_level);
      @(negedge clk);
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_err", rsp_err, exp_err);
    check("rsp_data", rsp_data, exp_data);
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        cmd_valid = 1'b1; cmd_op = ~op; cmd_data = 4'hF;
      end
      @(negedge clk);
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_rsp_data", rsp_data, exp_data);
      check("hold_rsp_err", rsp_err, exp_err);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_stk_en", stk_en, 0);
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_clear", rsp_valid, 0);
    check("rsp_err_clear", rsp_err, 0);
    check("cmd_ready_back", cmd_ready, 1);
    check("level", level, exp_level);
    if (exp_err && exp_errs < 255) exp_errs++;
`ifdef LIFO_CMD_ERR_CNT_EN
    check("err_cnt", err_cnt, exp_errs);
`endif
  endtask

  // Expected results come from a plain queue acting as the ideal bounded stack.
  task automatic model_cmd(input logic op, input logic [DW-1:0] data, input int hold);
    logic          err;
    logic [DW-1:0] d;
    d = '0;
    if (op) begin
      err = (ref_q.size() == 0);
      if (!err) d = ref_q.pop_back();
    end else begin
      err = (ref_q.size() >= DEPTH);
      if (!err) ref_q.push_back(data);
    end
    do_cmd(op, data, hold, err, d, ref_q.size());
  endtask

  initial begin
    tbl[0] = '{op: 1'b1, data: 4'h6, hold: 0, err: 1'b1, rdata: 4'h0, lvl: 0};
    tbl[1] = '{op: 1'b0, data: 4'h3, hold: 0, err: 1'b0, rdata: 4'h0, lvl: 1};
    tbl[2] = '{op: 1'b0, data: 4'hA, hold: 0, err: 1'b0, rdata: 4'h0, lvl: 2};
    tbl[3] = '{op: 1'b0, data: 4'h5, hold: 1, err: 1'b0, rdata: 4'h0, lvl: 3};
    tbl[4] = '{op: 1'b1, data: 4'h0, hold: 5, err: 1'b0, rdata: 4'h5, lvl: 2};
    tbl[5] = '{op: 1'b1, data: 4'h9, hold: 0, err: 1'b0, rdata: 4'hA, lvl: 1};
    tbl[6] = '{op: 1'b1, data: 4'h0, hold: 2, err: 1'b0, rdata: 4'h3, lvl: 0};
    tbl[7] = '{op: 1'b1, data: 4'h0, hold: 0, err: 1'b1, rdata: 4'h0, lvl: 0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_stk_en", stk_en, 0);
    check("rst_stk_rw", stk_rw, 0);
    check("rst_stk_din", stk_din, 0);
    check("rst_level", level, 0);
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_first_edge", cmd_ready, 1);

    for (int i = 0; i < 8; i++)
      do_cmd(tbl[i].op, tbl[i].data, tbl[i].hold, tbl[i].err, tbl[i].rdata, tbl[i].lvl);

    // Fill to DEPTH, overflow once, then pop the last value.
    for (int i = 0; i < DEPTH; i++) model_cmd(1'b0, DW'(i), 0);
    model_cmd(1'b0, 4'hC, 1);
    model_cmd(1'b1, 4'h0, 0);

    // Reset while a push sits in WAIT.
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_data = 4'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("wait_rst_stk_en", stk_en, 1);
    @(negedge clk);
    check("wait_rst_level_pre", level, 16);
    rst = 1'b1;
    #1;
    check("wait_rst_stk_en_low", stk_en, 0);
    check("wait_rst_level", level, 0);
    check("wait_rst_rsp_valid", rsp_valid, 0);
    check("wait_rst_cmd_ready", cmd_ready, 0);
    ref_q.delete();
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;

    for (int i = 0; i < 80; i++)
      model_cmd(($urandom_range(0, 99) < 58) ? 1'b0 : 1'b1, DW'($urandom), $urandom_range(0, 2));

    $display("rejected commands seen: %0d", exp_errs);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
